// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the packed-SIMD (Zpn) multiply datapath.
package ibex_pkg_pext;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PP_A_W = 33;
  localparam int unsigned PP_B_W = 17;
  localparam int unsigned PP_W   = PP_A_W + PP_B_W;
  localparam int unsigned ACC_W  = 2 * XLEN;

  typedef enum logic [1:0] {
    MSEQ_IDLE,
    MSEQ_MUL_HI,
    MSEQ_ACCUM
  } mult_seq_state_e;

  localparam logic [1:0] MSEQ_CYC_1 = 2'b00;
  localparam logic [1:0] MSEQ_CYC_2 = 2'b01;
  localparam logic [1:0] MSEQ_CYC_3 = 2'b11;

  // Signed 32b clamp of a 33b two's-complement sum.
  function automatic logic [XLEN-1:0] sat33_to_32(input logic [XLEN:0] s);
    if (s[XLEN] != s[XLEN-1]) begin
      sat33_to_32 = s[XLEN] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      sat33_to_32 = s[XLEN-1:0];
    end
  endfunction

endpackage

// File: rtl/ibex_mult_pext_pp.sv
// Combinational 33x17 signed partial-product multiplier.
module ibex_mult_pext_pp
  import ibex_pkg_pext::*;
(
  input  logic signed [PP_A_W-1:0] op_a_i,
  input  logic signed [PP_B_W-1:0] op_b_i,
  output logic signed [PP_W-1:0]   pp_o
);

  assign pp_o = PP_W'(op_a_i) * PP_W'(op_b_i);

endmodule

// File: rtl/ibex_mult_pext_seq.sv
// Multi-cycle sequencer for 32x32 Zpn multiplies: one 33x17 array reused over
// 2 or 3 cycles, optional doubling/rounding, accumulate into rd with saturation.
module ibex_mult_pext_seq
  import ibex_pkg_pext::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            mult_en_i,
  input  logic [1:0]      cycle_count_i,
  input  logic [1:0]      signed_mode_i,
  input  logic            high_i,
  input  logic            round_i,
  input  logic            doubling_i,
  input  logic            accum_i,
  input  logic            sub_i,
  input  logic            saturate_i,
  input  logic [XLEN-1:0] operand_a_i,
  input  logic [XLEN-1:0] operand_b_i,
  input  logic [XLEN-1:0] operand_c_i,
  input  logic [XLEN-1:0] fast_result_i,
  output logic [XLEN-1:0] result_o,
  output logic            ov_o,
  output logic            valid_o,
  output logic            busy_o
);

  mult_seq_state_e r_state, w_state_d;
  logic [ACC_W-1:0] r_acc, w_acc_d;

  logic signed [PP_A_W-1:0] w_a33;
  logic signed [PP_B_W-1:0] w_b17;
  logic signed [PP_W-1:0]   w_pp;
  logic [ACC_W-1:0]         w_pp_ext;
  logic [ACC_W-1:0]         w_prod;
  logic [ACC_W-1:0]         w_prod2;
  logic                     w_dbl_ov;
  logic [XLEN-1:0]          w_word;
  logic [XLEN:0]            w_c33;
  logic [XLEN:0]            w_w33;
  logic [XLEN:0]            w_sum33;
  logic                     w_sum_ov;
  logic [XLEN-1:0]          w_acc_res;
  logic                     w_acc_ov;

  // IDLE feeds the low half of b, MUL_HI the (optionally signed) high half.
  assign w_a33 = {signed_mode_i[0] & operand_a_i[XLEN-1], operand_a_i};
  assign w_b17 = (r_state == MSEQ_IDLE) ? {1'b0, operand_b_i[15:0]}
                                        : {signed_mode_i[1] & operand_b_i[XLEN-1],
                                           operand_b_i[XLEN-1:16]};

  ibex_mult_pext_pp u_pp (
    .op_a_i (w_a33),
    .op_b_i (w_b17),
    .pp_o   (w_pp)
  );

  assign w_pp_ext = ACC_W'(w_pp);
  assign w_prod   = r_acc + (w_pp_ext << 16);
  assign w_prod2  = (doubling_i ? (w_prod << 1) : w_prod)
                  + (round_i ? ACC_W'(64'h8000_0000) : ACC_W'(0));

  // Doubling overflows only for (-2^31)*(-2^31), visible as bits 63/62 differing.
  assign w_dbl_ov = doubling_i & (&signed_mode_i) & (w_prod[ACC_W-1] ^ w_prod[ACC_W-2]);
  assign w_word   = w_dbl_ov ? 32'h7FFF_FFFF
                  : (high_i ? w_prod2[ACC_W-1:XLEN] : w_prod2[XLEN-1:0]);

  assign w_c33     = {operand_c_i[XLEN-1], operand_c_i};
  assign w_w33     = {r_acc[XLEN-1], r_acc[XLEN-1:0]};
  assign w_sum33   = sub_i ? (w_c33 - w_w33) : (w_c33 + w_w33);
  assign w_sum_ov  = w_sum33[XLEN] ^ w_sum33[XLEN-1];
  assign w_acc_ov  = saturate_i & w_sum_ov;
  assign w_acc_res = saturate_i ? sat33_to_32(w_sum33) : w_sum33[XLEN-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= MSEQ_IDLE;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_d;
      r_acc   <= w_acc_d;
    end
  end

  // Next state, accumulator update and result/valid selection.
  always_comb begin
    w_state_d = r_state;
    w_acc_d   = r_acc;
    valid_o   = 1'b0;
    result_o  = '0;
    ov_o      = 1'b0;
    case (r_state)
      MSEQ_IDLE: begin
        if (mult_en_i) begin
          if (cycle_count_i == MSEQ_CYC_1) begin
            valid_o  = 1'b1;
            result_o = fast_result_i;
          end else begin
            w_acc_d   = w_pp_ext;
            w_state_d = MSEQ_MUL_HI;
          end
        end
      end
      MSEQ_MUL_HI: begin
        if (!mult_en_i) begin
          w_state_d = MSEQ_IDLE;
        end else if (cycle_count_i == MSEQ_CYC_3) begin
          w_acc_d   = {{XLEN{1'b0}}, w_word};
          w_state_d = MSEQ_ACCUM;
        end else begin
          valid_o   = 1'b1;
          result_o  = w_word;
          ov_o      = w_dbl_ov;
          w_state_d = MSEQ_IDLE;
        end
      end
      MSEQ_ACCUM: begin
        w_state_d = MSEQ_IDLE;
        if (mult_en_i) begin
          valid_o  = 1'b1;
          result_o = w_acc_res;
          ov_o     = w_acc_ov;
        end
      end
      default: w_state_d = MSEQ_IDLE;
    endcase
  end

  assign busy_o = (r_state != MSEQ_IDLE);

  // accum_i is implied by the 3-cycle count; kept for interface symmetry.
  logic w_unused;
  assign w_unused = accum_i;

endmodule
